ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Two-requester arbiter in front of the single-port word RAM (byte write enables, combinational read, negedge write).
- Requesters: m0 = load/store unit, m1 = instruction fetch.
- At most one access is granted per cycle, and the block drives the RAM port directly.
- Each requester gets a registered response through a valid/ready handshake, with at most one outstanding response per requester.

Parameters:
DATA_WIDTH, 32, word width; must be 32 (4 byte lanes)
ADDR_WIDTH, 10, word address width
DATA_NUM, 1024, RAM depth; passed through for documentation and assertions only

Ports:
clk  input  1  clock; all logic on posedge
srst_n  input  1  synchronous active-low reset
m0_req_valid  input  1  m0 request valid
m0_req_ready  output  1  m0 request accepted this cycle
m0_req_addr  input  ADDR_WIDTH  m0 word address
m0_req_wdata  input  DATA_WIDTH  m0 write data
m0_req_wen  input  4  m0 byte write enables; 0 means read
m0_rsp_valid  output  1  m0 response valid
m0_rsp_ready  input  1  m0 response consumed
m0_rsp_rdata  output  DATA_WIDTH  m0 read data; 0 for writes
m1_* (same 8 signals as m0_*)  same directions and widths  requester 1
ram_addr  output  ADDR_WIDTH  RAM address
ram_wdata  output  DATA_WIDTH  RAM write data
ram_ren  output  1  RAM read enable
ram_wen  output  4  RAM byte write enables
ram_rdata  input  DATA_WIDTH  RAM combinational read data

Behaviour:
- Reset (srst_n=0 at posedge): rsp_valid=0 and rsp_rdata=0 on both ports; pending flags cleared; rr_ptr=0 (m0 favoured next).
- In-flight state is discarded on reset; a request active in the reset cycle is not granted.
- Eligibility: mX is eligible when mX_req_valid=1 and mX has no held response. A response is held when rsp_valid=1 and rsp_ready=0 in the current cycle.
  - A response that is consumed in the same cycle frees the requester, so back-to-back grants are allowed.
- Arbitration: combinational.
  - One eligible requester: it wins.
  - Both eligible: the requester selected by rr_ptr wins, and rr_ptr is then set to the loser.
  - rr_ptr updates only on a contended grant.
- mX_req_ready = grant to mX; no other condition.
- RAM drive during a grant cycle:
  - ram_addr = winner addr.
  - ram_wdata = winner wdata.
  - ram_wen = winner wen.
  - ram_ren = (winner wen == 0).
- RAM drive when idle: ram_ren=0, ram_wen=0, ram_addr=0, ram_wdata=0. The RAM must never see a nonzero wen without a grant.
- Latency: the response is registered.
  - A grant at posedge N captures ram_rdata (read) or 0 (write) at that posedge.
  - rsp_valid=1 is visible from cycle N+1 and holds with stable data until rsp_ready=1 at a posedge.
- A write response is the completion ack. The RAM write lands on the negedge of the grant cycle, so a read to the same address granted in the next cycle returns the new data.
- Simultaneous consume and grant on the same port: rsp_valid stays 1 and rsp_rdata loads the new data.
- Cross-port ordering follows grant order only; there are no same-address hazards across ports beyond this.

Optional Feature:
- Macro RAM_ARB_FIXED_PRIO_EN.
- Defined: m0 always wins a contended cycle; rr_ptr is removed; fetch can starve under continuous LSU traffic.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package ram_arb_pkg holds:
  - port index constants ARB_M0=0 and ARB_M1=1;
  - a request struct typedef {addr, wdata, wen};
  - a response struct typedef {rdata}.
- One natural sub-module: ram_arb_rsp_slot. It is instantiated per port and holds the rsp_valid/rsp_rdata register and the busy flag.

Test Plan:
- Reset: srst_n=0 for 2 cycles with both requesters valid -> req_ready=0, rsp_valid=0, ram_wen=0 throughout.
- Single read: preload word 5 = 0xDEADBEEF; m1 reads addr 5 -> m1_req_ready=1 in cycle N, m1_rsp_valid=1 and rdata=0xDEADBEEF in cycle N+1.
- Byte write then read: m0 writes addr 3, wdata 0x11223344, wen=4'b0101, over prior 0xAABBCCDD; then m0 reads 3 -> 0xAA22CC44.
- Contention: both valid every cycle, rsp_ready=1 -> grants alternate m0,m1,m0,m1; with RAM_ARB_FIXED_PRIO_EN -> m0 granted every cycle, m1_req_ready never 1.
- Backpressure: m0_rsp_ready=0 for 4 cycles after a read -> m0 gets no further grant, rsp_rdata stable, m1 granted freely; releasing ready consumes the response and, with a new request pending, allows a same-cycle new grant.
- Mid-operation reset: assert srst_n=0 while m0 holds a response -> next cycle m0_rsp_valid=0 and rr_ptr=0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Optional fixed-priority build: RAM_ARB_FIXED_PRIO_EN.
package ram_arb_pkg;

   localparam int ARB_DW = 32;
   localparam int ARB_AW = 10;

   localparam logic ARB_M0 = 1'b0;
   localparam logic ARB_M1 = 1'b1;

   typedef struct packed {
      logic [ARB_AW-1:0] addr;
      logic [ARB_DW-1:0] wdata;
      logic [3:0]        wen;
   } req_t;

   typedef struct packed {
      logic [ARB_DW-1:0] rdata;
   } rsp_t;

endpackage

// File: rtl/ram_arb_rsp_slot.sv
// Per-requester response register: holds rsp_valid/rsp_rdata until consumed
// and reports when the requester is blocked by a held response.
module ram_arb_rsp_slot
   import ram_arb_pkg::*;
(
   input  logic              clk,
   input  logic              srst_n,
   input  logic              i_grant,
   input  logic [ARB_DW-1:0] i_cap_data,
   input  logic              i_rsp_ready,
   output logic              o_rsp_valid,
   output rsp_t              o_rsp,
   output logic              o_busy
);

   logic r_valid;
   rsp_t r_rsp;

   // A grant wins over a consume so back-to-back responses stay valid.
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         r_valid <= 1'b0;
         r_rsp   <= '0;
      end else if (i_grant) begin
         r_valid     <= 1'b1;
         r_rsp.rdata <= i_cap_data;
      end else if (i_rsp_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_busy      = r_valid & ~i_rsp_ready;
   assign o_rsp_valid = r_valid;
   assign o_rsp       = r_rsp;

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter driving a single-port word RAM (m0 = LSU, m1 = fetch).
// Define RAM_ARB_FIXED_PRIO_EN for fixed m0 priority instead of round-robin.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_NUM   = 1024
)
(
   input  logic                  clk,
   input  logic                  srst_n,
   input  logic                  m0_req_valid,
   output logic                  m0_req_ready,
   input  logic [ADDR_WIDTH-1:0] m0_req_addr,
   input  logic [DATA_WIDTH-1:0] m0_req_wdata,
   input  logic [3:0]            m0_req_wen,
   output logic                  m0_rsp_valid,
   input  logic                  m0_rsp_ready,
   output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
   input  logic                  m1_req_valid,
   output logic                  m1_req_ready,
   input  logic [ADDR_WIDTH-1:0] m1_req_addr,
   input  logic [DATA_WIDTH-1:0] m1_req_wdata,
   input  logic [3:0]            m1_req_wen,
   output logic                  m1_rsp_valid,
   input  logic                  m1_rsp_ready,
   output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic                  ram_ren,
   output logic [3:0]            ram_wen,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   if (DATA_WIDTH != ARB_DW || ADDR_WIDTH != ARB_AW || DATA_NUM > (1 << ADDR_WIDTH)) begin : g_bad_cfg
      $error("ram_port_arbiter: unsupported parameter set");
   end

   req_t [1:0]            w_req;
   rsp_t [1:0]            w_rsp;
   logic [1:0]            w_busy;
   logic [1:0]            w_elig;
   logic [1:0]            w_grant;
   logic [1:0]            w_rsp_valid;
   req_t                  w_win;
   logic                  w_ren;
   logic [DATA_WIDTH-1:0] w_cap_data;

   assign w_req[ARB_M0] = '{addr: m0_req_addr, wdata: m0_req_wdata, wen: m0_req_wen};
   assign w_req[ARB_M1] = '{addr: m1_req_addr, wdata: m1_req_wdata, wen: m1_req_wen};

   assign w_elig[ARB_M0] = m0_req_valid & ~w_busy[ARB_M0];
   assign w_elig[ARB_M1] = m1_req_valid & ~w_busy[ARB_M1];

`ifndef RAM_ARB_FIXED_PRIO_EN
   logic r_rr_ptr;

   // Pointer moves to the loser only when both requesters competed.
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         r_rr_ptr <= ARB_M0;
      end else if (&w_elig) begin
         r_rr_ptr <= ~r_rr_ptr;
      end
   end
`endif

   // Grant selection; nothing is granted while reset is asserted.
   always_comb begin
      w_grant = 2'b00;
      if (!srst_n) begin
         w_grant = 2'b00;
      end else if (&w_elig) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
         w_grant[ARB_M0] = 1'b1;
`else
         w_grant[r_rr_ptr] = 1'b1;
`endif
      end else begin
         w_grant = w_elig;
      end
   end

   // Winner mux; an idle port drives all zeros so no stray write enables.
   always_comb begin
      w_win = '0;
      if (w_grant[ARB_M1]) begin
         w_win = w_req[ARB_M1];
      end else if (w_grant[ARB_M0]) begin
         w_win = w_req[ARB_M0];
      end else begin
         w_win = '0;
      end
   end

   assign w_ren      = (|w_grant) & (w_win.wen == 4'b0000);
   assign w_cap_data = w_ren ? ram_rdata : '0;

   assign ram_addr  = w_win.addr;
   assign ram_wdata = w_win.wdata;
   assign ram_wen   = w_win.wen;
   assign ram_ren   = w_ren;

   ram_arb_rsp_slot u_slot_m0 (
      .clk         (clk),
      .srst_n      (srst_n),
      .i_grant     (w_grant[ARB_M0]),
      .i_cap_data  (w_cap_data),
      .i_rsp_ready (m0_rsp_ready),
      .o_rsp_valid (w_rsp_valid[ARB_M0]),
      .o_rsp       (w_rsp[ARB_M0]),
      .o_busy      (w_busy[ARB_M0])
   );

   ram_arb_rsp_slot u_slot_m1 (
      .clk         (clk),
      .srst_n      (srst_n),
      .i_grant     (w_grant[ARB_M1]),
      .i_cap_data  (w_cap_data),
      .i_rsp_ready (m1_rsp_ready),
      .o_rsp_valid (w_rsp_valid[ARB_M1]),
      .o_rsp       (w_rsp[ARB_M1]),
      .o_busy      (w_busy[ARB_M1])
   );

   assign m0_req_ready = w_grant[ARB_M0];
   assign m1_req_ready = w_grant[ARB_M1];
   assign m0_rsp_valid = w_rsp_valid[ARB_M0];
   assign m1_rsp_valid = w_rsp_valid[ARB_M1];
   assign m0_rsp_rdata = w_rsp[ARB_M0].rdata;
   assign m1_rsp_rdata = w_rsp[ARB_M1].rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed steps then random traffic
// against a transaction-level reference model and a behavioural RAM.
module tb_ram_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int DN = 1024;

   logic          clk = 1'b0;
   logic          srst_n;
   logic          m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready;
   logic [AW-1:0] m0_req_addr;
   logic [DW-1:0] m0_req_wdata, m0_rsp_rdata;
   logic [3:0]    m0_req_wen;
   logic          m1_req_valid, m1_req_ready, m1_rsp_valid, m1_rsp_ready;
   logic [AW-1:0] m1_req_addr;
   logic [DW-1:0] m1_req_wdata, m1_rsp_rdata;
   logic [3:0]    m1_req_wen;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;
   logic          ram_ren;
   logic [3:0]    ram_wen;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_NUM(DN)) dut (
      .clk(clk), .srst_n(srst_n),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
      .m0_req_wdata(m0_req_wdata), .m0_req_wen(m0_req_wen), .m0_rsp_valid(m0_rsp_valid),
      .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
      .m1_req_wdata(m1_req_wdata), .m1_req_wen(m1_req_wen), .m1_rsp_valid(m1_rsp_valid),
      .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ren(ram_ren),
      .ram_wen(ram_wen), .ram_rdata(ram_rdata)
   );

   // Behavioural single-port RAM: combinational read, byte-masked negedge write.
   logic [DW-1:0] mem [DN];
   logic          mem_init = 1'b0;
   assign ram_rdata = mem[ram_addr];

   always @(negedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < DN; i++) mem[i] <= '0;
         mem_init <= 1'b1;
      end else if (ram_wen != 4'b0000) begin
         for (int b = 0; b < 4; b++)
            if (ram_wen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
   end

   // Reference model state
   logic [DW-1:0] ref_mem [DN];
   bit            exp_valid [2];
   logic [DW-1:0] exp_data [2];
   int            fav;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int p, input bit v, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [3:0] w);
      if (p == 0) begin
         m0_req_valid = v; m0_req_addr = a; m0_req_wdata = d; m0_req_wen = w;
      end else begin
         m1_req_valid = v; m1_req_addr = a; m1_req_wdata = d; m1_req_wen = w;
      end
   endtask

   // Called at posedge+1 with inputs set; checks this cycle, advances the model.
   task automatic run_cycle();
      bit            v [2];
      bit            rdy [2];
      bit            elig [2];
      logic [AW-1:0] a [2];
      logic [DW-1:0] d [2];
      logic [3:0]    w [2];
      int            win;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      logic [3:0]    e_wen;
      #2;
      v[0] = m0_req_valid; rdy[0] = m0_rsp_ready; a[0] = m0_req_addr; d[0] = m0_req_wdata; w[0] = m0_req_wen;
      v[1] = m1_req_valid; rdy[1] = m1_rsp_ready; a[1] = m1_req_addr; d[1] = m1_req_wdata; w[1] = m1_req_wen;
      for (int i = 0; i < 2; i++) elig[i] = v[i] && !(exp_valid[i] && !rdy[i]);
      win = -1;
      if (srst_n) begin
         if (elig[0] && elig[1]) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            win = 0;
`else
            win = fav;
`endif
         end else if (elig[0]) win = 0;
         else if (elig[1]) win = 1;
      end
      e_addr = '0; e_wdata = '0; e_wen = 4'b0000;
      if (win >= 0) begin
         e_addr = a[win]; e_wdata = d[win]; e_wen = w[win];
      end
      check("m0_req_ready", 64'(m0_req_ready), 64'(win == 0));
      check("m1_req_ready", 64'(m1_req_ready), 64'(win == 1));
      check("ram_addr", 64'(ram_addr), 64'(e_addr));
      check("ram_wdata", 64'(ram_wdata), 64'(e_wdata));
      check("ram_wen", 64'(ram_wen), 64'(e_wen));
      check("ram_ren", 64'(ram_ren), 64'(win >= 0 && e_wen == 4'b0000));
      check("m0_rsp_valid", 64'(m0_rsp_valid), 64'(exp_valid[0]));
      check("m1_rsp_valid", 64'(m1_rsp_valid), 64'(exp_valid[1]));
      if (exp_valid[0]) check("m0_rsp_rdata", 64'(m0_rsp_rdata), 64'(exp_data[0]));
      if (exp_valid[1]) check("m1_rsp_rdata", 64'(m1_rsp_rdata), 64'(exp_data[1]));
      @(posedge clk);
      if (!srst_n) begin
         for (int i = 0; i < 2; i++) begin
            exp_valid[i] = 1'b0;
            exp_data[i]  = '0;
         end
         fav = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (i == win) begin
               exp_valid[i] = 1'b1;
               exp_data[i]  = (w[i] == 4'b0000) ? ref_mem[a[i]] : '0;
            end else if (exp_valid[i] && rdy[i]) begin
               exp_valid[i] = 1'b0;
            end
         end
         if (win >= 0)
            for (int b = 0; b < 4; b++)
               if (w[win][b]) ref_mem[a[win]][8*b +: 8] = d[win][8*b +: 8];
         if (elig[0] && elig[1]) fav = 1 - win;
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < DN; i++) ref_mem[i] = '0;
      for (int i = 0; i < 2; i++) begin
         exp_valid[i] = 1'b0;
         exp_data[i]  = '0;
      end
      fav = 0;
      srst_n = 1'b0;
      m0_rsp_ready = 1'b1;
      m1_rsp_ready = 1'b1;
      set_req(0, 1'b0, '0, '0, 4'b0000);
      set_req(1, 1'b0, '0, '0, 4'b0000);
      @(posedge clk);
      #1;

      // Reset held two cycles with both requesters asking
      set_req(0, 1'b1, 10'd1, 32'h0000_0001, 4'b1111);
      set_req(1, 1'b1, 10'd2, 32'h0000_0002, 4'b0000);
      repeat (2) run_cycle();
      check("m0_rdata_after_reset", 64'(m0_rsp_rdata), 64'h0);
      check("m1_rdata_after_reset", 64'(m1_rsp_rdata), 64'h0);
      srst_n = 1'b1;
      set_req(1, 1'b0, '0, '0, 4'b0000);

      // Preload words 5 and 3 through m0
      set_req(0, 1'b1, 10'd5, 32'hDEAD_BEEF, 4'b1111);
      run_cycle();
      set_req(0, 1'b1, 10'd3, 32'hAABB_CCDD, 4'b1111);
      run_cycle();
      set_req(0, 1'b0, '0, '0, 4'b0000);
      run_cycle();

      // Single read by m1
      set_req(1, 1'b1, 10'd5, '0, 4'b0000);
      run_cycle();
      set_req(1, 1'b0, '0, '0, 4'b0000);
      check("m1_single_read_valid", 64'(m1_rsp_valid), 64'h1);
      check("m1_single_read_data", 64'(m1_rsp_rdata), 64'hDEAD_BEEF);
      run_cycle();

      // Byte write then read-back in the next cycle
      set_req(0, 1'b1, 10'd3, 32'h1122_3344, 4'b0101);
      run_cycle();
      check("m0_write_ack_data", 64'(m0_rsp_rdata), 64'h0);
      set_req(0, 1'b1, 10'd3, '0, 4'b0000);
      run_cycle();
      set_req(0, 1'b0, '0, '0, 4'b0000);
      check("m0_byte_merge", 64'(m0_rsp_rdata), 64'hAA22_CC44);
      run_cycle();

      // Contention with both responses consumed every cycle
      set_req(0, 1'b1, 10'd3, '0, 4'b0000);
      set_req(1, 1'b1, 10'd5, '0, 4'b0000);
      repeat (6) run_cycle();
      set_req(0, 1'b0, '0, '0, 4'b0000);
      set_req(1, 1'b0, '0, '0, 4'b0000);
      run_cycle();

      // Backpressure on m0 while m1 keeps being served
      set_req(0, 1'b1, 10'd5, '0, 4'b0000);
      run_cycle();
      m0_rsp_ready = 1'b0;
      set_req(0, 1'b1, 10'd3, '0, 4'b0000);
      set_req(1, 1'b1, 10'd5, '0, 4'b0000);
      repeat (4) run_cycle();
      check("m0_held_data", 64'(m0_rsp_rdata), 64'hDEAD_BEEF);
      m0_rsp_ready = 1'b1;
      set_req(1, 1'b0, '0, '0, 4'b0000);
      run_cycle();
      set_req(0, 1'b0, '0, '0, 4'b0000);
      check("m0_consume_and_regrant", 64'(m0_rsp_rdata), 64'hAA22_CC44);
      run_cycle();

      // Reset while m0 holds a response
      m0_rsp_ready = 1'b0;
      set_req(0, 1'b1, 10'd5, '0, 4'b0000);
      set_req(1, 1'b1, 10'd3, '0, 4'b0000);
      repeat (2) run_cycle();
      srst_n = 1'b0;
      run_cycle();
      srst_n = 1'b1;
      m0_rsp_ready = 1'b1;
      check("m0_valid_after_midreset", 64'(m0_rsp_valid), 64'h0);
      repeat (3) run_cycle();

      // Random traffic over a small address window to provoke hazards
      for (int n = 0; n < 600; n++) begin
         srst_n       = ($urandom_range(0, 59) != 0);
         m0_rsp_ready = ($urandom_range(0, 3) != 0);
         m1_rsp_ready = ($urandom_range(0, 3) != 0);
         set_req(0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
         set_req(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
         run_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
